// File: rtl/gpio_bus_arbiter_if.sv
// Shared bus bundle for gpio_bus_arbiter: requester side
// (valid/ready/response) plus the single GPIO slave port.
interface gpio_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic                      chip_select;
  logic                      write_enable;
  logic                      read_enable;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         write_data;
  logic [DATA_W-1:0]         read_data;

  // Arbiter view: it masters the GPIO slave port.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  read_data,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output chip_select, write_enable, read_enable,
    output addr, write_data
  );

  // Environment view: requesters and the GPIO slave.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output read_data,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  chip_select, write_enable, read_enable,
    input  addr, write_data
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one GPIO slave port.
// Define GPIO_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module gpio_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  gpio_bus_arbiter_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                write_q, write_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                win_vld;
  logic [IDW-1:0]      win_id;
  logic [IDW-1:0]      cand;
  logic                win_wr;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

`ifndef GPIO_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW:0]        sum;
`endif

  // Pick the winner: first pending index from the search start.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
    sum     = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef GPIO_ARB_FIXED_PRIO_EN
      cand = IDW'(k);
`else
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      cand = sum[IDW-1:0];
`endif
      if (!win_vld && bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Extract the winning requester's payload.
  always_comb begin
    win_wr    = bus.req_write[win_id];
    win_addr  = ADDR_W'(bus.req_addr >> (ADDR_W * int'(win_id)));
    win_wdata = DATA_W'(bus.req_wdata >> (DATA_W * int'(win_id)));
  end

  // Sequencer: next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    write_d     = write_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d             = ISSUE;
          id_d                = win_id;
          write_d             = win_wr;
          req_ready_d[win_id] = 1'b1;
          cs_d                = 1'b1;
          we_d                = win_wr;
          re_d                = !win_wr;
          addr_d              = win_addr;
          wdata_d             = win_wr ? win_wdata : '0;
        end
      end
      ISSUE: begin
        state_d           = RESP;
        rsp_valid_d[id_q] = 1'b1;
        rsp_rdata_d       = write_q ? '0 : bus.read_data;
      end
      RESP: begin
        state_d = IDLE;
`ifndef GPIO_ARB_FIXED_PRIO_EN
        ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= '0;
      write_q     <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      re_q        <= re_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifndef GPIO_ARB_FIXED_PRIO_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.busy         = busy_q;
  assign bus.chip_select  = cs_q;
  assign bus.write_enable = we_q;
  assign bus.read_enable  = re_q;
  assign bus.addr         = addr_q;
  assign bus.write_data   = wdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Testbench for gpio_bus_arbiter: transaction-level model,
// per-cycle compare, directed literal checks and random traffic.
module tb_gpio_bus_arbiter;

  localparam int NR = 3;
  localparam int AW = NR * 32;

  typedef struct packed {
    logic [NR-1:0] rdy;
    logic [NR-1:0] rsp;
    logic [31:0]   rdata;
    logic          busy;
    logic          cs;
    logic          we;
    logic          re;
    logic [31:0]   addr;
    logic [31:0]   wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   run_cmp = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] mem  [16] = '{default: '0};
  logic [31:0] mmem [16] = '{default: '0};
  exp_t        ring [4]  = '{default: '0};
  int          cyc = 0;
  int          free_at = 0;
  int          ptr = 0;
  bit          pend_vld = 1'b0;
  logic [3:0]  pend_a = '0;
  logic [31:0] pend_d = '0;

  logic [31:0] wlog [$];
  int          clog [$];

  gpio_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32)) bus ();

  gpio_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.read_data = mem[bus.addr[3:0]];

  always @(posedge clk) begin
    if (bus.chip_select && bus.write_enable)
      mem[bus.addr[3:0]] <= bus.write_data;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: each accepted request books its
  // grant/slave cycle and its response cycle in a small ring.
  always @(posedge clk or negedge rst) begin : model
    int w;
    int idx;
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    if (!rst) begin
      for (int i = 0; i < 4; i++) ring[i] = '0;
      ptr = 0;
      free_at = 0;
      pend_vld = 1'b0;
    end else begin
      if (pend_vld) mmem[pend_a] = pend_d;
      pend_vld = 1'b0;
      cyc++;
      ring[2'(cyc + 1)] = '0;
      if (cyc >= free_at && bus.req_valid != '0) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
`ifdef GPIO_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (ptr + k) % NR;
`endif
          if (w < 0 && ((bus.req_valid >> idx) & NR'(1)) != '0) w = idx;
        end
        wr = ((bus.req_write >> w) & NR'(1)) != '0;
        a  = 32'(bus.req_addr >> (32 * w));
        d  = 32'(bus.req_wdata >> (32 * w));
        ring[2'(cyc)].rdy   = NR'(1) << w;
        ring[2'(cyc)].busy  = 1'b1;
        ring[2'(cyc)].cs    = 1'b1;
        ring[2'(cyc)].we    = wr;
        ring[2'(cyc)].re    = !wr;
        ring[2'(cyc)].addr  = a;
        ring[2'(cyc)].wdata = wr ? d : 32'h0;
        ring[2'(cyc + 1)].rsp   = NR'(1) << w;
        ring[2'(cyc + 1)].busy  = 1'b1;
        ring[2'(cyc + 1)].rdata = wr ? 32'h0 : mmem[a[3:0]];
        if (wr) begin
          pend_vld = 1'b1;
          pend_a   = a[3:0];
          pend_d   = d;
        end
        ptr = (w + 1) % NR;
        free_at = cyc + 3;
      end
    end
  end

  // Per-cycle compare against the model plus protocol invariants.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (run_cmp) begin
      e = ring[2'(cyc)];
      chk("req_ready", 64'(bus.req_ready), 64'(e.rdy));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.rsp));
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
      chk("busy", 64'(bus.busy), 64'(e.busy));
      chk("chip_select", 64'(bus.chip_select), 64'(e.cs));
      chk("write_enable", 64'(bus.write_enable), 64'(e.we));
      chk("read_enable", 64'(bus.read_enable), 64'(e.re));
      chk("addr", 64'(bus.addr), 64'(e.addr));
      chk("write_data", 64'(bus.write_data), 64'(e.wdata));
      chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
      chk("rsp_onehot0", 64'($onehot0(bus.rsp_valid)), 64'd1);
      chk("we_re_excl", 64'(bus.write_enable & bus.read_enable), 64'd0);
      if (bus.chip_select && bus.write_enable) begin
        wlog.push_back(bus.write_data);
        clog.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    logic [NR-1:0] m;
    m = NR'(1) << i;
    bus.req_valid = bus.req_valid | m;
    bus.req_write = wr ? (bus.req_write | m) : (bus.req_write & ~m);
    bus.req_addr  = (bus.req_addr & ~(AW'(32'hFFFF_FFFF) << (32 * i)))
                  | (AW'(a) << (32 * i));
    bus.req_wdata = (bus.req_wdata & ~(AW'(32'hFFFF_FFFF) << (32 * i)))
                  | (AW'(d) << (32 * i));
  endtask

  task automatic clr_req(input int i);
    bus.req_valid = bus.req_valid & ~(NR'(1) << i);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b0;
    repeat (3) tick();

    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_cs", 64'(bus.chip_select), 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    rst = 1'b1;
    run_cmp = 1'b1;

    repeat (10) begin
      tick();
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("idle_strobes",
          64'({bus.chip_select, bus.write_enable, bus.read_enable}), 64'd0);
    end

    set_req(0, 1'b1, 32'h0, 32'hA5A5_00FF);
    tick();
    chk("wr_ready", 64'(bus.req_ready), 64'b001);
    chk("wr_cs", 64'(bus.chip_select), 64'd1);
    chk("wr_we", 64'(bus.write_enable), 64'd1);
    chk("wr_re", 64'(bus.read_enable), 64'd0);
    chk("wr_data", 64'(bus.write_data), 64'hA5A5_00FF);
    clr_req(0);
    tick();
    chk("wr_rsp", 64'(bus.rsp_valid), 64'b001);
    chk("wr_rdata", 64'(bus.rsp_rdata), 64'd0);
    tick();

    set_req(1, 1'b0, 32'h0, 32'h1234_5678);
    tick();
    chk("rd_ready", 64'(bus.req_ready), 64'b010);
    chk("rd_re", 64'(bus.read_enable), 64'd1);
    chk("rd_wdata", 64'(bus.write_data), 64'd0);
    clr_req(1);
    tick();
    chk("rd_rsp", 64'(bus.rsp_valid), 64'b010);
    chk("rd_rdata", 64'(bus.rsp_rdata), 64'hA5A5_00FF);
    tick();

    wlog.delete();
    clog.delete();
    set_req(0, 1'b1, 32'h1, 32'h1);
    set_req(1, 1'b1, 32'h2, 32'h2);
    repeat (13) tick();
    clr_req(0);
    clr_req(1);
    repeat (4) tick();
    chk("cont_count", 64'(wlog.size() >= 4), 64'd1);
    if (wlog.size() >= 4) begin
`ifdef GPIO_ARB_FIXED_PRIO_EN
      chk("cont_w0", 64'(wlog[0]), 64'h1);
      chk("cont_w1", 64'(wlog[1]), 64'h1);
      chk("cont_w2", 64'(wlog[2]), 64'h1);
      chk("cont_w3", 64'(wlog[3]), 64'h1);
`else
      chk("cont_w0", 64'(wlog[0]), 64'h1);
      chk("cont_w1", 64'(wlog[1]), 64'h2);
      chk("cont_w2", 64'(wlog[2]), 64'h1);
      chk("cont_w3", 64'(wlog[3]), 64'h2);
`endif
      chk("cont_gap", 64'(clog[1] - clog[0]), 64'd3);
    end

    set_req(1, 1'b1, 32'h5, 32'hDEAD_BEEF);
    tick();
    chk("mid_ready", 64'(bus.req_ready), 64'b010);
    chk("mid_cs", 64'(bus.chip_select), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cs", 64'(bus.chip_select), 64'd0);
    chk("mid_rst_we", 64'(bus.write_enable), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_rst_addr", 64'(bus.addr), 64'd0);
    chk("mid_rst_wdata", 64'(bus.write_data), 64'd0);
    tick();
    chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("mid_nowrite", 64'(mem[5]), 64'd0);
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("post_rst_grant", 64'(bus.req_ready), 64'b001);
    clr_req(0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready[i])
          clr_req(i);
        else if (bus.req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) clr_req(i);
        end else if ($urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom(), $urandom());
      end
      if (!rst)
        rst = 1'b1;
      else if ($urandom_range(0, 299) == 0)
        rst = 1'b0;
    end

    bus.req_valid = '0;
    rst = 1'b1;
    repeat (4) tick();
    repeat (10) begin
      tick();
      chk("end_idle_busy", 64'(bus.busy), 64'd0);
      chk("end_idle_cs", 64'(bus.chip_select), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
Name: gpio_bus_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one memory-mapped GPIO output peripheral slave port between NUM_REQ bus requesters (e.g. CPU core and a pattern/DMA engine).
- Accepts one request at a time and drives the slave's chip_select/write_enable/read_enable/addr/write_data for exactly one cycle.
- Captures the slave's combinational read_data and returns a one-cycle response to the originating requester.
- Sits between the requesters and the GPIO output IP; the slave is unmodified.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NUM_REQ  per-requester request pending; held until req_ready.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data; same packing.
- req_ready  output  NUM_REQ  one-hot accept pulse.
- rsp_valid  output  NUM_REQ  one-hot response pulse, for reads and writes.
- rsp_rdata  output  DATA_W  read data, valid with rsp_valid; 0 for writes.
- busy  output  1  high when state != IDLE.
- chip_select  output  1  to slave.
- write_enable  output  1  to slave.
- read_enable  output  1  to slave.
- addr  output  ADDR_W  to slave.
- write_data  output  DATA_W  to slave.
- read_data  input  DATA_W  from slave (combinational).

Behaviour:
- All outputs registered.
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0, chip_select = write_enable = read_enable = 0, addr = 0, write_data = 0, FSM = IDLE, round-robin pointer = 0.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - If any req_valid, select the winner: first asserted index searching from pointer upward, wrapping modulo NUM_REQ.
  - Latch winner id, addr, wdata and write.
  - Pulse req_ready[id] in the cycle after the accept edge (cycle T+1), together with ISSUE.
  - With no req_valid, stay in IDLE; slave signals stay 0.
- ISSUE (one cycle):
  - chip_select = 1; write_enable = latched write; read_enable = !latched write.
  - addr and write_data hold latched values (write_data = 0 on reads).
  - At the closing edge, capture read_data into rsp_rdata for reads; 0 for writes.
  - Go to RESP.
- RESP (one cycle):
  - rsp_valid[id] = 1; slave strobes = 0.
  - Pointer <= (id + 1) mod NUM_REQ; go to IDLE.
- Latency: request sampled at edge T -> slave access cycle T+1 -> rsp_valid cycle T+2.
- Throughput: 1 transaction per 3 cycles.
- Requesters must hold req_valid and payload until req_ready. A requester may re-request in the cycle after its rsp_valid.
- A req_valid that drops before req_ready is ignored; no error.
- Simultaneous requests: exactly one grant per transaction; no requester waits more than NUM_REQ-1 transactions.
- req_valid changes during ISSUE/RESP do not affect the in-flight transaction.
- Reset mid-operation (rst low in any state):
  - Immediate return to IDLE with all reset values.
  - In-flight transaction dropped, no rsp_valid.
  - A slave write is not generated after reset assertion.
- Never more than one bit of req_ready or rsp_valid set.
- write_enable and read_enable never both 1.
- Pointer update is modulo NUM_REQ for non-power-of-2 NUM_REQ.

Optional Feature:
- Macro GPIO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, index 0 highest; pointer logic removed; a persistent lower-index requester may starve higher indices.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single write: req 0 writes addr 0x0, data 0xA5A5_00FF -> req_ready[0] at T+1; chip_select = write_enable = 1 with write_data 0xA5A5_00FF at T+1; rsp_valid[0] at T+2; rsp_rdata = 0.
- Read-back: after the write, req 1 reads -> read_enable = 1 in ISSUE; rsp_valid[1] with rsp_rdata 0xA5A5_00FF two cycles after accept.
- Contention, round-robin: req 0 and req 1 held continuously, writing 0x1 and 0x2 -> grants alternate 0,1,0,1 at a 3-cycle spacing; slave sees 0x1, 0x2, 0x1, 0x2.
- Contention with GPIO_ARB_FIXED_PRIO_EN defined: same stimulus -> req 0 granted every transaction, req 1 never granted while req 0 is held.
- Reset mid-ISSUE: drive rst = 0 during ISSUE of a write of 0xDEAD_BEEF -> all outputs 0 immediately, no rsp_valid; after rst = 1, next grant goes to requester 0.
- Idle/protocol checks: no req_valid for 10 cycles -> busy = 0 and strobes = 0. Assertions throughout: req_ready and rsp_valid one-hot-or-zero; write_enable and read_enable never both 1.
